// File: rtl/key_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : key_ctrl_pkg
// Description : Shared state encoding, default timing constants and helper
//               functions for the key press controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package key_ctrl_pkg;

  // Press-classification FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } fsm_state_t;

  // Default timing constants (cycles at 50 MHz)
  localparam int unsigned DEF_LONG_TIME   = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_TIME = 5_000_000;   // 0.1 s

  // Default DDS tuning word range and step
  localparam logic [31:0] DEF_FWORD_INIT = 32'd85_899;
  localparam logic [31:0] DEF_FWORD_STEP = 32'd85_899;
  localparam logic [31:0] DEF_FWORD_MIN  = 32'd85_899;
  localparam logic [31:0] DEF_FWORD_MAX  = 32'd858_993_459;

  // Larger of two unsigned values; used to size the shared cycle counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Next tuning word after one step. Comparing against (hi - step) rather than
  // forming cur + step keeps the arithmetic inside 32 bits with no overflow.
  function automatic logic [31:0] fword_advance(
    input logic [31:0] cur,
    input logic [31:0] step,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    if (cur > (hi - step)) begin
      return lo;
    end
    return cur + step;
  endfunction

endpackage : key_ctrl_pkg
`default_nettype wire

// File: rtl/key_press_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : key_press_ctrl
// Description : Classifies debounced key presses as short or long. A short
//               press advances the waveform select; a long press steps the
//               DDS frequency word once, then auto-repeats while held.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module key_press_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned LONG_TIME   = DEF_LONG_TIME,
  parameter int unsigned REPEAT_TIME = DEF_REPEAT_TIME,
  parameter logic [31:0] FWORD_INIT  = DEF_FWORD_INIT,
  parameter logic [31:0] FWORD_STEP  = DEF_FWORD_STEP,
  parameter logic [31:0] FWORD_MIN   = DEF_FWORD_MIN,
  parameter logic [31:0] FWORD_MAX   = DEF_FWORD_MAX
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        key_flag,
  input  logic        key_state,
  output logic        short_pulse,
  output logic        step_pulse,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_word
);

  // One counter serves both the long-press and the repeat interval
  localparam int unsigned CNT_MAX = max_u(LONG_TIME, REPEAT_TIME);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             short_nxt;
  logic             step_nxt;
  logic [1:0]       wave_nxt;
  logic [31:0]      fword_nxt;

  logic             press_evt;
  logic             release_evt;

  // Decode debouncer edges; key_state is only meaningful alongside key_flag
  assign press_evt   = key_flag & ~key_state;
  assign release_evt = key_flag &  key_state;

  // Next-state, counter and output-register decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    step_nxt  = 1'b0;
    wave_nxt  = wave_sel;
    fword_nxt = freq_word;

    case (state)
      IDLE: begin
        // Release edges seen while idle carry no meaning and are dropped
        if (press_evt) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end

      PRESS: begin
        // A release on the terminal-count cycle still counts as short.
        // A repeated press edge is ignored: counting simply continues.
        if (release_evt) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
          wave_nxt  = wave_sel + 2'd1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          step_nxt  = 1'b1;
          fword_nxt = fword_advance(freq_word, FWORD_STEP, FWORD_MIN, FWORD_MAX);
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      HOLD: begin
        // Release wins over a coincident repeat step
        if (release_evt) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nxt   = '0;
          step_nxt  = 1'b1;
          fword_nxt = fword_advance(freq_word, FWORD_STEP, FWORD_MIN, FWORD_MAX);
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any press in progress
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      short_pulse <= 1'b0;
      step_pulse  <= 1'b0;
      wave_sel    <= 2'd0;
      freq_word   <= FWORD_INIT;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      short_pulse <= short_nxt;
      step_pulse  <= step_nxt;
      wave_sel    <= wave_nxt;
      freq_word   <= fword_nxt;
    end
  end

endmodule : key_press_ctrl
`default_nettype wire

// File: tb/tb_key_press_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_key_press_ctrl
// Description : Self-checking bench for key_press_ctrl. The reference model
//               tracks only "key held since cycle N" and derives pulses from
//               elapsed hold time with plain arithmetic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_key_press_ctrl;

  localparam int unsigned LT   = 10;
  localparam int unsigned RT   = 4;
  localparam logic [31:0] FINI = 32'd100;
  localparam logic [31:0] FSTP = 32'd50;
  localparam logic [31:0] FMIN = 32'd100;
  localparam logic [31:0] FMAX = 32'd300;

  logic        Clk;
  logic        Reset_n;
  logic        key_flag;
  logic        key_state;
  logic        short_pulse;
  logic        step_pulse;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;

  key_press_ctrl #(
    .LONG_TIME  (LT),
    .REPEAT_TIME(RT),
    .FWORD_INIT (FINI),
    .FWORD_STEP (FSTP),
    .FWORD_MIN  (FMIN),
    .FWORD_MAX  (FMAX)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .key_flag   (key_flag),
    .key_state  (key_state),
    .short_pulse(short_pulse),
    .step_pulse (step_pulse),
    .wave_sel   (wave_sel),
    .freq_word  (freq_word)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: key held or not, cycle of the accepted press, expected outputs
  int          cyc      = 0;
  bit          held     = 0;
  int          t_press  = 0;
  bit          exp_short;
  bit          exp_step;
  int          exp_wave;
  longint      exp_freq;
  int          n_short  = 0;
  int          n_step   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("short_pulse", 32'(short_pulse), 32'(exp_short));
    chk("step_pulse",  32'(step_pulse),  32'(exp_step));
    chk("wave_sel",    32'(wave_sel),    32'(exp_wave));
    chk("freq_word",   freq_word,        32'(exp_freq));
    chk("pulse_excl",  32'(short_pulse & step_pulse), 32'd0);
  endtask

  // Advance the model for the inputs presented in the current cycle
  task automatic model_step(input bit f, input bit s);
    int el;
    exp_short = 0;
    exp_step  = 0;
    if (!held) begin
      if (f && !s) begin
        held    = 1;
        t_press = cyc;
      end
    end else begin
      el = cyc - t_press;
      if (f && s) begin
        held = 0;
        if (el <= int'(LT)) begin
          exp_short = 1;
          exp_wave  = (exp_wave + 1) % 4;
          n_short++;
        end
      end else if (el >= int'(LT) && ((el - int'(LT)) % int'(RT)) == 0) begin
        exp_step = 1;
        n_step++;
        if (exp_freq + longint'(FSTP) > longint'(FMAX)) exp_freq = longint'(FMIN);
        else exp_freq = exp_freq + longint'(FSTP);
      end
    end
  endtask

  task automatic tick(input bit f, input bit s);
    @(negedge Clk);
    key_flag  = f;
    key_state = s;
    model_step(f, s);
    @(posedge Clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset asserted between edges, held for n cycles
  task automatic do_reset(input int n);
    @(negedge Clk);
    key_flag  = 1'b0;
    key_state = 1'b1;
    Reset_n   = 1'b0;
    held      = 0;
    exp_short = 0;
    exp_step  = 0;
    exp_wave  = 0;
    exp_freq  = longint'(FINI);
    #1;
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      cyc++;
      check_all();
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic short_press(input int len);
    tick(1'b1, 1'b0);
    idle(len - 1);
    tick(1'b1, 1'b1);
  endtask

  initial begin
    key_flag  = 1'b0;
    key_state = 1'b1;
    Reset_n   = 1'b1;
    exp_wave  = 0;
    exp_freq  = longint'(FINI);

    // Reset values
    do_reset(3);
    idle(2);

    // Short press: release 5 cycles after press
    short_press(5);
    idle(3);
    chk("short_count", 32'(wave_sel), 32'd1);
    chk("short_freq",  freq_word, 32'd100);

    // Long press: held long enough for five steps, wrapping the word
    tick(1'b1, 1'b0);
    idle(27);
    tick(1'b1, 1'b1);
    idle(3);
    chk("long_freq_wrap", freq_word, 32'd100);
    chk("long_wave_kept", 32'(wave_sel), 32'd1);

    // Boundary: release on the terminal-count cycle is a short press
    short_press(int'(LT));
    idle(3);
    chk("boundary_wave", 32'(wave_sel), 32'd2);
    chk("boundary_freq", freq_word, 32'd100);

    // Wrap: four short presses cycle wave_sel back to the same value
    for (int k = 0; k < 4; k++) begin
      short_press(int'($urandom_range(1, LT)));
      idle(2);
    end

    // Reset three cycles into HOLD, then a normal short press
    tick(1'b1, 1'b0);
    idle(int'(LT) + 3);
    do_reset(2);
    idle(2);
    short_press(5);
    idle(2);
    chk("post_reset_wave", 32'(wave_sel), 32'd1);

    // Spurious edges: release while idle, press while pressed
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b0);
    idle(int'(LT) + 2 * int'(RT));
    tick(1'b1, 1'b1);
    idle(2);

    // Spurious press while in HOLD
    tick(1'b1, 1'b0);
    idle(int'(LT) + 1);
    tick(1'b1, 1'b0);
    idle(int'(RT) + 2);
    tick(1'b1, 1'b1);
    idle(2);

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (!held) begin
        tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 11) == 0) tick(1'b1, 1'($urandom_range(0, 2) != 0));
        else tick(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    idle(3);

    // Both kinds of event must have been seen
    chk("saw_short", 32'(n_short > 5), 32'd1);
    chk("saw_step",  32'(n_step > 5),  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_press_ctrl
`default_nettype wire
